// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
//
// Owns the single write port of the register file. After reset (and on
// clr_start) it walks every register from 0 to NUM_REGS-1, writing zero,
// one write per cycle. Once that clear pass is done it arbitrates between
// two writeback requesters with valid/ready handshakes:
//   A = pipeline writeback, B = load/multiply unit.
// Contention is resolved round-robin. The write port outputs are
// registered. Writes to register 0 are accepted but dropped.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   clr_start     one-cycle pulse, re-runs the clear pass (ignored while clearing)
//   a_valid/a_ready/a_addr/a_data   requester A handshake and payload
//   b_valid/b_ready/b_addr/b_data   requester B handshake and payload
//   rf_regWrite   registered write enable to the register file
//   rf_writeReg   registered write address
//   rf_writeData  registered write data
//   init_busy     high while the clear pass runs
module regfile_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_start,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_regWrite,
    output logic [ADDR_W-1:0] rf_writeReg,
    output logic [DATA_W-1:0] rf_writeData,
    output logic              init_busy
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    // Requester identity for the round-robin pointer.
    typedef enum logic {
        GR_A = 1'b0,
        GR_B = 1'b1
    } grant_t;

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    state_t              state_q,      state_d;
    logic [ADDR_W-1:0]   cnt_q,        cnt_d;
    grant_t              last_grant_q, last_grant_d;
    logic                rf_we_q,      rf_we_d;
    logic [ADDR_W-1:0]   rf_addr_q,    rf_addr_d;
    logic [DATA_W-1:0]   rf_data_q,    rf_data_d;

    logic arb_ok;
    logic a_hs;
    logic b_hs;

    // clr_start takes priority over any grant in the cycle it is seen.
    assign arb_ok  = (state_q == ST_ARB) && !clr_start;

    // A requester that is not contended for is always ready; under
    // contention the one that did not win last time gets the slot.
    assign a_ready = arb_ok && (!b_valid || (last_grant_q == GR_B));
    assign b_ready = arb_ok && (!a_valid || (last_grant_q == GR_A));

    assign a_hs    = a_valid && a_ready;
    assign b_hs    = b_valid && b_ready;

    assign init_busy    = (state_q == ST_INIT);
    assign rf_regWrite  = rf_we_q;
    assign rf_writeReg  = rf_addr_q;
    assign rf_writeData = rf_data_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        rf_we_d      = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_data_d    = rf_data_q;

        unique case (state_q)
            ST_INIT: begin
                rf_we_d   = 1'b1;
                rf_addr_d = cnt_q;
                rf_data_d = '0;
                if (cnt_q == LAST_REG) begin
                    cnt_d   = '0;
                    state_d = ST_ARB;
                end else begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                end
            end

            ST_ARB: begin
                if (clr_start) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else if (a_hs) begin
                    rf_we_d      = (a_addr != '0);
                    rf_addr_d    = a_addr;
                    rf_data_d    = a_data;
                    last_grant_d = GR_A;
                end else if (b_hs) begin
                    rf_we_d      = (b_addr != '0);
                    rf_addr_d    = b_addr;
                    rf_data_d    = b_data;
                    last_grant_d = GR_B;
                end
            end

            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            last_grant_q <= GR_B;
            rf_we_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_addr_q    <= rf_addr_d;
            rf_data_q    <= rf_data_d;
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Testbench for regfile_port_arbiter: table-driven ARB-phase vectors plus
// hand-written sequences for the clear pass, clr_start and reset aborts.
module tb_regfile_port_arbiter;

    logic        clk;
    logic        reset;
    logic        clr_start;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        rf_regWrite;
    logic [4:0]  rf_writeReg;
    logic [31:0] rf_writeData;
    logic        init_busy;

    int checks   = 0;
    int failures = 0;

    regfile_port_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_REGS (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clr_start    (clr_start),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .rf_regWrite  (rf_regWrite),
        .rf_writeReg  (rf_writeReg),
        .rf_writeData (rf_writeData),
        .init_busy    (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        ear;
        logic        ebr;
        logic        ewe;
        logic [4:0]  eaddr;
        logic [31:0] edata;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mkv(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                                 input logic ear, input logic ebr, input logic ewe,
                                 input logic [4:0] eaddr, input logic [31:0] edata);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.bv = bv; v.ba = ba; v.bd = bd;
        v.ear = ear; v.ebr = ebr; v.ewe = ewe;
        v.eaddr = eaddr; v.edata = edata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] addr,
                          input logic [31:0] data);
        chk({tag, "_we"},   32'(rf_regWrite),  32'(we));
        chk({tag, "_addr"}, 32'(rf_writeReg),  32'(addr));
        chk({tag, "_data"}, rf_writeData,      data);
    endtask

    // Runs the 32-write clear pass from its first edge; leaves the DUT in ARB.
    task automatic run_clear(input string tag);
        for (int i = 0; i < 32; i++) begin
            chk({tag, "_busy"},    32'(init_busy), 32'd1);
            chk({tag, "_a_ready"}, 32'(a_ready),   32'd0);
            chk({tag, "_b_ready"}, 32'(b_ready),   32'd0);
            step();
            chk_rf($sformatf("%s_clr%0d", tag, i), 1'b1, 5'(i), 32'd0);
        end
        chk({tag, "_busy_done"}, 32'(init_busy), 32'd0);
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        clr_start = 1'b0;
    endtask

    initial begin
        vecs[0]  = mkv(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,        1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        vecs[1]  = mkv(1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF);
        vecs[2]  = mkv(1'b0, 5'd0, 32'd0,        1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF);
        vecs[3]  = mkv(1'b1, 5'd3, 32'd1,        1'b1, 5'd7, 32'd11,       1'b1, 1'b0, 1'b1, 5'd3, 32'd1);
        vecs[4]  = mkv(1'b1, 5'd3, 32'd2,        1'b1, 5'd7, 32'd11,       1'b0, 1'b1, 1'b1, 5'd7, 32'd11);
        vecs[5]  = mkv(1'b1, 5'd3, 32'd2,        1'b1, 5'd7, 32'd12,       1'b1, 1'b0, 1'b1, 5'd3, 32'd2);
        vecs[6]  = mkv(1'b1, 5'd3, 32'd3,        1'b1, 5'd7, 32'd12,       1'b0, 1'b1, 1'b1, 5'd7, 32'd12);
        vecs[7]  = mkv(1'b1, 5'd3, 32'd3,        1'b1, 5'd7, 32'd13,       1'b1, 1'b0, 1'b1, 5'd3, 32'd3);
        vecs[8]  = mkv(1'b1, 5'd3, 32'd4,        1'b1, 5'd7, 32'd13,       1'b0, 1'b1, 1'b1, 5'd7, 32'd13);
        vecs[9]  = mkv(1'b1, 5'd3, 32'd4,        1'b1, 5'd7, 32'd14,       1'b1, 1'b0, 1'b1, 5'd3, 32'd4);
        vecs[10] = mkv(1'b0, 5'd0, 32'd0,        1'b1, 5'd7, 32'd14,       1'b0, 1'b1, 1'b1, 5'd7, 32'd14);
        vecs[11] = mkv(1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        1'b1, 1'b1, 1'b0, 5'd7, 32'd14);

        // Reset held with both requesters asserting: nothing may be ready.
        idle_inputs();
        reset   = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        repeat (3) step();
        chk_rf("reset", 1'b0, 5'd0, 32'd0);
        chk("reset_busy",    32'(init_busy), 32'd1);
        chk("reset_a_ready", 32'(a_ready),   32'd0);
        chk("reset_b_ready", 32'(b_ready),   32'd0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        #1;

        run_clear("init");
        step();
        chk_rf("post_init", 1'b0, 5'd31, 32'd0);

        // Table-driven ARB vectors: readies before the edge, rf_* after it.
        for (int i = 0; i < 12; i++) begin
            a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
            #1;
            chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].ear));
            chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].ebr));
            step();
            chk_rf($sformatf("v%0d", i), vecs[i].ewe, vecs[i].eaddr, vecs[i].edata);
        end
        idle_inputs();

        // clr_start blocks a pending A request, clears, then A goes through.
        a_valid   = 1'b1;
        a_addr    = 5'd9;
        a_data    = 32'h55;
        clr_start = 1'b1;
        #1;
        chk("clr_a_ready", 32'(a_ready), 32'd0);
        chk("clr_b_ready", 32'(b_ready), 32'd0);
        step();
        clr_start = 1'b0;
        chk("clr_we_off", 32'(rf_regWrite), 32'd0);
        run_clear("reclr");
        chk("reclr_a_ready", 32'(a_ready), 32'd1);
        step();
        chk_rf("reclr_a_write", 1'b1, 5'd9, 32'h55);
        idle_inputs();
        step();
        chk("reclr_idle_we", 32'(rf_regWrite), 32'd0);

        // Reset in ARB the cycle after a handshake drops the presented write.
        a_valid = 1'b1;
        a_addr  = 5'd12;
        a_data  = 32'hAA;
        step();
        idle_inputs();
        chk_rf("arb_hs", 1'b1, 5'd12, 32'hAA);
        reset = 1'b0;
        #1;
        chk_rf("arb_rst", 1'b0, 5'd0, 32'd0);
        chk("arb_rst_busy", 32'(init_busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;

        // Reset part-way through the clear pass restarts it at register 0.
        for (int i = 0; i < 10; i++) begin
            step();
            chk_rf($sformatf("part_clr%0d", i), 1'b1, 5'(i), 32'd0);
        end
        reset = 1'b0;
        #1;
        chk_rf("init_rst", 1'b0, 5'd0, 32'd0);
        chk("init_rst_busy", 32'(init_busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        run_clear("restart");
        step();
        chk_rf("restart_idle", 1'b0, 5'd31, 32'd0);

        // First contention after reset goes to A.
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h100;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h200;
        #1;
        chk("rr_rst_a_ready", 32'(a_ready), 32'd1);
        chk("rr_rst_b_ready", 32'(b_ready), 32'd0);
        step();
        chk_rf("rr_rst_a", 1'b1, 5'd1, 32'h100);
        a_valid = 1'b0;
        #1;
        chk("rr_rst_b_ready2", 32'(b_ready), 32'd1);
        step();
        chk_rf("rr_rst_b", 1'b1, 5'd2, 32'h200);
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- After reset, sequences a hardware clear of all registers through that port.
- Then arbitrates between two writeback requesters: A is the pipeline writeback, B is the load/multiply unit.
- Uses valid/ready handshakes, round-robin on contention, registered outputs to the write port, and never writes register 0.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register address.
- NUM_REGS, 32, registers cleared by the init sequence (must be at most 2^ADDR_W).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- clr_start  input  1  one-cycle pulse; re-runs the clear sequence.
- a_valid  input  1  requester A has a write pending.
- a_ready  output  1  requester A write accepted this cycle.
- a_addr  input  ADDR_W  requester A destination register.
- a_data  input  DATA_W  requester A write data.
- b_valid  input  1  requester B has a write pending.
- b_ready  output  1  requester B write accepted this cycle.
- b_addr  input  ADDR_W  requester B destination register.
- b_data  input  DATA_W  requester B write data.
- rf_regWrite  output  1  register-file write enable (registered).
- rf_writeReg  output  ADDR_W  register-file write address (registered).
- rf_writeData  output  DATA_W  register-file write data (registered).
- init_busy  output  1  high while the clear sequence runs.

Behaviour:
- Reset (reset low, async):
  - state=INIT, cnt=0, last_grant=B.
  - rf_regWrite=0, rf_writeReg=0, rf_writeData=0, init_busy=1.
  - a_ready=b_ready=0.
- States: INIT, ARB.
- INIT, at each edge:
  - rf_regWrite<=1, rf_writeReg<=cnt, rf_writeData<=0, cnt<=cnt+1.
  - If cnt==NUM_REGS-1: cnt<=0, state<=ARB.
  - After release, edges 1..NUM_REGS present writes to regs 0..NUM_REGS-1, one per cycle with no gaps.
  - a_ready=b_ready=0 throughout INIT.
- init_busy = (state==INIT), combinational from state.
- ARB, readies (combinational):
  - a_ready = a_valid_ok & (!b_valid | last_grant==B), where a_valid_ok = (state==ARB & !clr_start).
  - b_ready = a_valid_ok & (!a_valid | last_grant==A).
  - Only one of a_ready/b_ready is high in any cycle when both valids are high.
  - A ready may be high without its valid; a handshake requires valid&ready.
- ARB, on an edge with a handshake on X:
  - rf_writeReg<=X_addr, rf_writeData<=X_data, rf_regWrite<=(X_addr!=0), last_grant<=X.
  - Latency: a request accepted at edge N is presented on rf_* during cycle N..N+1 and committed by the register file at edge N+1.
- ARB, edge with no handshake: rf_regWrite<=0; rf_writeReg and rf_writeData hold their values.
- Address 0 is accepted (ready and handshake normal) but dropped: rf_regWrite=0.
- Round-robin: last_grant updates on every grant, including uncontended ones. First contention after reset grants A.
- Requester rule: once valid is high, addr, data and valid must stay stable until ready. The arbiter does not buffer.
- clr_start:
  - In ARB it has priority: no handshake that cycle.
  - Next edge: state<=INIT, cnt<=0, rf_regWrite<=0.
  - Clear writes start on the following edge. Pending requests wait.
  - Ignored while in INIT.
- Reset asserted mid-INIT or mid-ARB aborts immediately. Any in-flight registered write is lost (rf_regWrite=0). The sequence restarts from reg 0 after release.
- Throughput: one write per cycle in ARB, never two. Under sustained contention A and B alternate.

Test Plan:
- Reset low 3 cycles, then release; a_valid=b_valid=0 -> edges 1..32 show rf_regWrite=1, rf_writeReg=0..31, rf_writeData=0; init_busy falls after edge 32; edge 33 shows rf_regWrite=0.
- After init, a_valid=1, a_addr=5, a_data=32'hDEADBEEF for one handshake -> a_ready=1 that cycle; next cycle rf_regWrite=1, rf_writeReg=5, rf_writeData=32'hDEADBEEF; the cycle after, rf_regWrite=0.
- Both valid continuously (A addr 3/data 1..4, B addr 7/data 11..14, each advancing on its ready) -> grants A,B,A,B,...; rf_writeReg sequence 3,7,3,7,... with matching data; never both readies high.
- b_valid=1, b_addr=0, b_data=32'hFFFFFFFF -> b_ready=1, handshake completes; next cycle rf_regWrite=0; last_grant=B (a following contention grants A).
- clr_start pulsed while a_valid=1 -> a_ready=0 that cycle; init_busy=1 next; 32 clear writes; A is then granted and written after the clear.
- reset pulsed low at INIT cycle 10 and again in ARB the cycle after a handshake -> outputs zero immediately, the pending write never appears, and the clear restarts at reg 0.
